// File: rtl/g_inv.sv
// Iterative inverse of the G mixing step: undoes the second half-step (H2)
// and then the first half-step (H1) on consecutive cycles, with valid/ready on both sides.
module g_inv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] c_i,
  input  logic [31:0] d_i,
  input  logic [31:0] para0,
  input  logic [31:0] para1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a_o,
  output logic [31:0] b_o,
  output logic [31:0] c_o,
  output logic [31:0] d_o,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    H2   = 2'd1,
    H1   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_a, r_b, r_c, r_d;
  logic [31:0] r_p0, r_p1;

  logic [31:0] w_h2_a, w_h2_b, w_h2_c, w_h2_d;
  logic [31:0] w_h1_a, w_h1_b, w_h1_c, w_h1_d;

  // Undo the second half-step; a1 uses the freshly recovered b1.
  always_comb begin
    w_h2_b = {r_b[24:0], r_b[31:25]} ^ r_c;
    w_h2_c = r_c - r_d;
    w_h2_d = {r_d[23:0], r_d[31:24]} ^ r_a;
    w_h2_a = r_a - w_h2_b - r_p1;
  end

  // Undo the first half-step; a uses the freshly recovered b.
  always_comb begin
    w_h1_b = {r_b[19:0], r_b[31:20]} ^ r_c;
    w_h1_c = r_c - r_d;
    w_h1_d = {r_d[15:0], r_d[31:16]} ^ r_a;
    w_h1_a = r_a - w_h1_b - r_p0;
  end

  always_comb begin
    // NOTE: default assigned first so no path leaves w_state_nxt unassigned (no latch).
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (in_valid) w_state_nxt = H2;
      H2:      w_state_nxt = H1;
      H1:      w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a  <= '0;
      r_b  <= '0;
      r_c  <= '0;
      r_d  <= '0;
      r_p0 <= '0;
      r_p1 <= '0;
    end else begin
      unique case (r_state)
        IDLE: if (in_valid) begin
          r_a  <= a_i;
          r_b  <= b_i;
          r_c  <= c_i;
          r_d  <= d_i;
          r_p0 <= para0;
          r_p1 <= para1;
        end
        H2: begin
          r_a <= w_h2_a;
          r_b <= w_h2_b;
          r_c <= w_h2_c;
          r_d <= w_h2_d;
        end
        H1: begin
          r_a <= w_h1_a;
          r_b <= w_h1_b;
          r_c <= w_h1_c;
          r_d <= w_h1_d;
        end
        default: ;  // DONE holds the result stable under backpressure
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign a_o       = r_a;
  assign b_o       = r_b;
  assign c_o       = r_c;
  assign d_o       = r_d;

endmodule
